// File: rtl/verdict_pkg.sv
// verdict_pkg: FSM states and stream count shared by the verdict collector.
package verdict_pkg;
  localparam int STREAM_CNT = 2;
  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} fsm_state_t;
endpackage

// File: rtl/verdict_fifo.sv
// verdict_fifo: synchronous FIFO; a push into a full FIFO is accepted when a pop shares the edge.
module verdict_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_wr, w_rd;
  assign o_full  = r_cnt == CAP;
  assign o_empty = r_cnt == '0;
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_wr);
      r_rp  <= r_rp + AW'(w_rd);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk) if (w_wr) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/verdict_collector.sv
// verdict_collector: timestamps active monitor output cycles, buffers them, and drains one record per active stream.
module verdict_collector
  import verdict_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] output_0,
  input  logic              output_0_aktv,
  input  logic [DATA_W-1:0] output_1,
  input  logic              output_1_aktv,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic              rec_id,
  output logic [DATA_W-1:0] rec_data,
  output logic [TS_W-1:0]   rec_time,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);
  typedef struct packed {
    logic [TS_W-1:0]       ts;
    logic [STREAM_CNT-1:0] aktv;
    logic [DATA_W-1:0]     out0;
    logic [DATA_W-1:0]     out1;
  } entry_t;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [TS_W-1:0] r_ts;
  entry_t r_cur, w_head, w_in;
  fsm_state_t r_state, w_next;
  logic [CW-1:0] w_count;
  logic [DROP_W-1:0] r_drops;
  logic r_ovf, w_full, w_empty, w_cap, w_pop, w_hs, w_last, w_drop;
  assign w_in   = '{ts: r_ts, aktv: {output_1_aktv, output_0_aktv}, out0: output_0, out1: output_1};
  assign w_cap  = en & (output_0_aktv | output_1_aktv);
  assign w_hs   = rec_valid & rec_ready;
  assign w_last = (r_state == EMIT1) | ((r_state == EMIT0) & ~r_cur.aktv[1]);
  // Loading the next entry on the last handshake keeps one record per cycle across entries.
  assign w_pop  = ~w_empty & ((r_state == IDLE) | (w_hs & w_last));
  assign w_drop = w_cap & w_full & ~w_pop;
  verdict_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cap),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_comb begin
    w_next = r_state;
    if (w_pop) w_next = w_head.aktv[0] ? EMIT0 : EMIT1;
    else if (w_hs) w_next = ((r_state == EMIT0) && r_cur.aktv[1]) ? EMIT1 : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ts    <= '0;
      r_state <= IDLE;
      r_cur   <= '0;
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end else begin
      r_ts    <= r_ts + TS_W'(en);
      r_state <= w_next;
      if (w_pop) r_cur <= w_head;
      if (w_drop) r_ovf <= 1'b1;
      if (w_drop && !(&r_drops)) r_drops <= r_drops + DROP_W'(1);
    end
  end
  assign rec_valid  = r_state != IDLE;
  assign rec_id     = r_state == EMIT1;
  assign rec_data   = rec_id ? r_cur.out1 : r_cur.out0;
  assign rec_time   = r_cur.ts;
  assign overflow   = r_ovf;
  assign drop_count = r_drops;
  ap_count: assert property (@(posedge clk) disable iff (!rst)
    (w_full == (w_count == CW'(DEPTH))) && (w_empty == (w_count == '0)));
endmodule
